// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive/transmit encodings and defaults
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SAMPLE_POINT_DEF = 7;
  typedef enum logic [2:0] {IDLE, START_CHK, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {BITS5, BITS6, BITS7, BITS8} data_bits_t;
  function automatic logic [7:0] align_data(input logic [7:0] sh, input logic [1:0] nb);
    return sh >> (2'd3 - nb);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: loopback mux, 2-flop synchronizer and falling-edge detect
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_serial_data,
  input  logic i_int_serial_data,
  input  logic i_loopback_en,
  output logic o_line,
  output logic o_fall
);
  logic s1, prev;
  // Reset to 0 so a line stuck low never looks like a fresh start edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      o_line <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= i_loopback_en ? i_int_serial_data : i_serial_data;
      o_line <= s1;
      prev <= o_line;
    end
  end
  assign o_fall = prev & ~o_line;
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 16x oversampled UART receiver; UART_RX_MAJORITY_VOTE_EN enables 3-sample bit voting
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SAMPLE_POINT = SAMPLE_POINT_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_serial_data,
  input  logic       i_int_serial_data,
  input  logic       i_loopback_en,
  input  logic       i_rx_en16,
  input  logic       i_parity_en,
  input  logic       i_parity_even,
  input  logic       i_stick_parity_en,
  input  logic [1:0] i_no_of_data_bits,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_parity_err,
  output logic       o_framing_err,
  output logic       o_break_int,
  output logic       o_rx_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int START_DEC = SAMPLE_POINT + 1;
`else
  localparam int START_DEC = SAMPLE_POINT;
`endif
  logic line, fall;
  rx_state_t state;
  logic [TW-1:0] tick;
  logic [2:0] nbit;
  logic [7:0] sh, data_a;
  logic [1:0] vote, nb_q;
  logic par_en_q, even_q, stick_q, par_q;
  logic dec, bit_s, exp_par;
  uart_rx_sync u_sync (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_serial_data(i_serial_data),
    .i_int_serial_data(i_int_serial_data),
    .i_loopback_en(i_loopback_en),
    .o_line(line),
    .o_fall(fall)
  );
  // After the start check the counter restarts, so later decisions fall on the last tick of each period
  always_comb begin
    dec = i_rx_en16 && (tick == (state == START_CHK ? TW'(START_DEC) : TW'(OVERSAMPLE - 1)));
`ifdef UART_RX_MAJORITY_VOTE_EN
    bit_s = (vote[1] & vote[0]) | (vote[1] & line) | (vote[0] & line);
`else
    bit_s = line;
`endif
    data_a = align_data(sh, nb_q);
    exp_par = stick_q ? ~even_q : (even_q ? ^data_a : ~^data_a);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      tick <= '0;
      nbit <= '0;
      sh <= '0;
      vote <= '0;
      nb_q <= '0;
      par_en_q <= 1'b0;
      even_q <= 1'b0;
      stick_q <= 1'b0;
      par_q <= 1'b0;
      o_rx_data <= '0;
      o_rx_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_framing_err <= 1'b0;
      o_break_int <= 1'b0;
      o_rx_busy <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      if (i_rx_en16) begin
        tick <= tick + 1'b1;
        vote <= {vote[0], line};
      end
      if (dec) tick <= '0;
      case (state)
        IDLE: begin
          tick <= '0;
          if (fall) begin
            state <= START_CHK;
            nbit <= '0;
            sh <= '0;
            par_q <= 1'b0;
            nb_q <= i_no_of_data_bits;
            par_en_q <= i_parity_en;
            even_q <= i_parity_even;
            stick_q <= i_stick_parity_en;
            o_rx_busy <= 1'b1;
          end
        end
        START_CHK: if (dec) begin
          state <= bit_s ? IDLE : DATA;
          o_rx_busy <= ~bit_s;
        end
        DATA: if (dec) begin
          sh <= {bit_s, sh[7:1]};
          nbit <= nbit + 1'b1;
          if (nbit == {1'b0, nb_q} + 3'd4) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: if (dec) begin
          par_q <= bit_s;
          state <= STOP;
        end
        STOP: if (dec) begin
          state <= IDLE;
          o_rx_busy <= 1'b0;
          o_rx_valid <= 1'b1;
          o_rx_data <= data_a;
          o_parity_err <= par_en_q && (par_q != exp_par);
          o_framing_err <= ~bit_s;
          o_break_int <= ~bit_s && (data_a == 8'h00) && ~par_q;
        end
        default: begin
          state <= IDLE;
          o_rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: scoreboard bench for uart_rx_fsm with directed frames
module tb_uart_rx_fsm;
  logic clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic tx = 1'b1, lb = 1'b0;
  logic [1:0] tcnt = 2'd0;
  logic i_serial_data, i_int_serial_data, i_loopback_en, i_rx_en16;
  logic i_parity_en = 1'b0, i_parity_even = 1'b0, i_stick_parity_en = 1'b0;
  logic [1:0] i_no_of_data_bits = 2'd3;
  logic [7:0] o_rx_data;
  logic o_rx_valid, o_parity_err, o_framing_err, o_break_int, o_rx_busy;
  typedef struct {logic [7:0] d; logic pe, fe, bi;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, vcount = 0, vc;

  always #5 clk = ~clk;
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign i_rx_en16 = (tcnt == 2'd3);
  assign i_serial_data = lb ? 1'b0 : tx;
  assign i_int_serial_data = lb ? tx : 1'b1;
  assign i_loopback_en = lb;

  uart_rx_fsm dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_serial_data(i_serial_data),
    .i_int_serial_data(i_int_serial_data), .i_loopback_en(i_loopback_en),
    .i_rx_en16(i_rx_en16), .i_parity_en(i_parity_en), .i_parity_even(i_parity_even),
    .i_stick_parity_en(i_stick_parity_en), .i_no_of_data_bits(i_no_of_data_bits),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_parity_err(o_parity_err),
    .o_framing_err(o_framing_err), .o_break_int(o_break_int), .o_rx_busy(o_rx_busy)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (i_rst_n && o_rx_valid) begin
      vcount++;
      if (q.size() == 0) chk("unexpected_valid", 8'd1, 8'd0);
      else begin
        e = q.pop_front();
        chk("rx_data", o_rx_data, e.d);
        chk("parity_err", {7'd0, o_parity_err}, {7'd0, e.pe});
        chk("framing_err", {7'd0, o_framing_err}, {7'd0, e.fe});
        chk("break_int", {7'd0, o_break_int}, {7'd0, e.bi});
      end
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk iff i_rx_en16);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input bit g);
    for (int j = 0; j < 16; j++) begin
      tx = (g && j == 7) ? ~b : b;
      tick_wait(1);
    end
  endtask

  task automatic frame(input logic [7:0] d, input int n, input bit pen, input logic pb,
                       input logic stop, input int gbit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i], i == gbit);
    if (pen) send_bit(pb, 1'b0);
    send_bit(stop, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic bi);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.bi = bi;
    q.push_back(e);
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 4000 && q.size() != 0; i++) @(posedge clk);
    chk(nm, 8'(q.size()), 8'd0);
  endtask

  task automatic cfg(input logic [1:0] nb, input logic pen, input logic ev, input logic st);
    i_no_of_data_bits = nb; i_parity_en = pen; i_parity_even = ev; i_stick_parity_en = st;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", o_rx_data, 8'h00);
    chk("rst_flags", {3'd0, o_rx_valid, o_parity_err, o_framing_err, o_break_int, o_rx_busy}, 8'h00);
    i_rst_n = 1'b1;
    tick_wait(20);
    cfg(2'd3, 1'b0, 1'b0, 1'b0);
    push(8'hA5, 0, 0, 0);
    frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    wait_empty("f_8n1");
    cfg(2'd2, 1'b1, 1'b1, 1'b0);
    push(8'h35, 0, 0, 0);
    frame(8'h35, 7, 1'b1, 1'b0, 1'b1, -1);
    push(8'h35, 1, 0, 0);
    frame(8'h35, 7, 1'b1, 1'b1, 1'b1, -1);
    wait_empty("f_7e1");
    cfg(2'd0, 1'b1, 1'b0, 1'b0);
    push(8'h1F, 0, 1, 0);
    frame(8'h1F, 5, 1'b1, 1'b0, 1'b0, -1);
    push(8'h0A, 0, 0, 0);
    frame(8'h0A, 5, 1'b1, 1'b1, 1'b1, -1);
    wait_empty("f_5o1");
    cfg(2'd1, 1'b1, 1'b1, 1'b1);
    push(8'h2A, 0, 0, 0);
    frame(8'h2A, 6, 1'b1, 1'b0, 1'b1, -1);
    push(8'h2A, 1, 0, 0);
    frame(8'h2A, 6, 1'b1, 1'b1, 1'b1, -1);
    wait_empty("f_stick");
    cfg(2'd3, 1'b1, 1'b1, 1'b0);
    push(8'h00, 0, 1, 1);
    tx = 1'b0;
    tick_wait(12 * 16);
    wait_empty("f_break");
    vc = vcount;
    tick_wait(8 * 16);
    chk("break_no_retrigger", 8'(vcount - vc), 8'd0);
    tx = 1'b1;
    tick_wait(32);
    push(8'hC3, 0, 0, 0);
    frame(8'hC3, 8, 1'b1, 1'b0, 1'b1, -1);
    wait_empty("f_after_break");
    vc = vcount;
    tx = 1'b0;
    tick_wait(4);
    tx = 1'b1;
    tick_wait(1);
    chk("glitch_busy", {7'd0, o_rx_busy}, 8'd1);
    tick_wait(6);
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_idle", {7'd0, o_rx_busy}, 8'd0);
    tick_wait(32);
    chk("glitch_no_valid", 8'(vcount - vc), 8'd0);
`ifdef UART_RX_MAJORITY_VOTE_EN
    cfg(2'd3, 1'b0, 1'b0, 1'b0);
    push(8'h81, 0, 0, 0);
    frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 3);
    wait_empty("f_vote");
`endif
    cfg(2'd3, 1'b0, 1'b0, 1'b0);
    lb = 1'b1;
    tick_wait(16);
    push(8'h5A, 0, 0, 0);
    frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
    wait_empty("f_loopback");
    vc = vcount;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("mid_busy", {7'd0, o_rx_busy}, 8'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_data", o_rx_data, 8'h00);
    chk("mid_rst_flags", {3'd0, o_rx_valid, o_parity_err, o_framing_err, o_break_int, o_rx_busy}, 8'h00);
    tx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    tick_wait(12 * 16);
    chk("mid_rst_no_valid", 8'(vcount - vc), 8'd0);
    chk("mid_rst_idle", {7'd0, o_rx_busy}, 8'd0);
    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
